// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter: default sizing,
// FSM state encoding and a small one-hot helper.
package fifo_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int DW_DEF    = 8;
  localparam int BURST_DEF = 4;

  localparam int WR_CNT_W = 16;
  // Wide enough for BURST up to 16.
  localparam int BCNT_W   = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Decodes an index into an 8-bit one-hot vector; callers truncate to N_REQ.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    logic [7:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Requester and FIFO write-port bundle shared by the arbiter and its neighbours.
// slave: the arbiter side; master: the requesters plus FIFO write controller.
interface fifo_wr_arb_if
  import fifo_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] data_in;
  logic [N_REQ-1:0]    gnt;
  logic                w_full;
  logic                w_en;
  logic [DW-1:0]       w_data;

  modport slave (
    input  req,
    input  data_in,
    input  w_full,
    output gnt,
    output w_en,
    output w_data
  );

  modport master (
    output req,
    output data_in,
    output w_full,
    input  gnt,
    input  w_en,
    input  w_data
  );

endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// Circular first-one search: returns the first set req bit at or after rr_ptr.
// Purely combinational; N_REQ must be a power of two so the index wraps naturally.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     valid
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] w_idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    winner = rr_ptr;
    valid  = 1'b0;
    w_idx  = '0;
    // Scan farthest-first so the closest hit to rr_ptr is the last one written.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = rr_ptr + IW'(k);
      if (req[w_idx]) begin
        winner = w_idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter feeding one FIFO write port from N_REQ requesters.
// Each grant takes up to BURST words, then one IDLE cycle re-arbitrates.
module fifo_wr_arb
  import fifo_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF,
  parameter int BURST = BURST_DEF
) (
  input  logic                     w_clk,
  input  logic                     rst_n,
  fifo_wr_arb_if.slave             bus,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic [WR_CNT_W-1:0]      wr_cnt
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [IW-1:0]       r_owner;
  logic [IW-1:0]       w_owner_nxt;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       w_rr_ptr_nxt;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [BCNT_W-1:0]   w_bcnt_nxt;
  logic [WR_CNT_W-1:0] r_wr_cnt;

  logic [IW-1:0]       w_pick;
  logic                w_pick_vld;
  logic                w_owner_req;
  logic                w_wen;
  logic                w_last_word;
  logic [7:0]          w_owner_oh;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req    (bus.req),
    .rr_ptr (r_rr_ptr),
    .winner (w_pick),
    .valid  (w_pick_vld)
  );

  assign w_owner_req = bus.req[r_owner];
  assign w_wen       = (r_state == ST_GRANT) && w_owner_req && !bus.w_full;
  assign w_last_word = (r_bcnt == BCNT_W'(BURST - 1));
  assign w_owner_oh  = onehot8(3'(r_owner));

  assign bus.w_en   = w_wen;
  assign bus.w_data = bus.data_in[r_owner*DW +: DW];
  assign bus.gnt    = w_wen ? w_owner_oh[N_REQ-1:0] : '0;

  assign owner  = r_owner;
  assign busy   = (r_state == ST_GRANT);
  assign wr_cnt = r_wr_cnt;

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_bcnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_bcnt   <= w_bcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_bcnt_nxt   = r_bcnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = ST_GRANT;
          w_owner_nxt = w_pick;
          w_bcnt_nxt  = '0;
        end
      end
      ST_GRANT: begin
        // A dropped request ends the grant even if the FIFO is also full.
        if (!w_owner_req) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = r_owner + 1'b1;
        end else if (w_wen) begin
          w_bcnt_nxt = r_bcnt + 1'b1;
          if (w_last_word) begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = r_owner + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
    end else if (w_wen) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
    end
  end

endmodule
